// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM side of the EX/MEM pipeline register.
// Converts a latched load/store into a req/ack data-memory transaction,
// stalls upstream while it is outstanding, and registers the MEM/WB slot.
// Optional feature macro: MEM_TIMEOUT_EN (abort an access after TIMEOUT cycles).
module mem_access_stage #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         i_clock,
  input  logic         i_reset,        // asynchronous, active-low
  input  logic         i_valid_mem,
  input  logic         i_wr_en_mem,
  input  logic         i_wd_sel_mem,
  input  logic         i_wm_en_mem,
  input  logic [4:0]   i_rw_mem,
  input  logic [N-1:0] i_alu_result_mem,
  input  logic [N-1:0] i_rdb_mem,
  output logic         o_stall,
  output logic         o_dmem_req,
  output logic         o_dmem_we,
  output logic [N-1:0] o_dmem_addr,
  output logic [N-1:0] o_dmem_wdata,
  input  logic [N-1:0] i_dmem_rdata,
  input  logic         i_dmem_ack,
  output logic         o_valid_wb,
  output logic         o_wr_en_wb,
  output logic [4:0]   o_rw_wb,
  output logic [N-1:0] o_result_wb,
  output logic         o_timeout_err
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t       r_state;
  logic         r_dmem_req;
  logic         r_dmem_we;
  logic [N-1:0] r_addr;
  logic [N-1:0] r_wdata;
  logic [4:0]   r_rw;
  logic         r_wr_en;
  logic         r_wd_sel;
  logic         r_wm_en;
  logic         r_valid_wb;
  logic         r_wr_en_wb;
  logic [4:0]   r_rw_wb;
  logic [N-1:0] r_result_wb;
  logic         r_timeout_err;

  logic         w_mem_op;
  logic         w_is_load;
  logic         w_to;
  logic         w_stall;

  // A slot with both wd_sel and wm_en set is a store.
  assign w_mem_op  = i_valid_mem & (i_wd_sel_mem | i_wm_en_mem);
  assign w_is_load = r_wd_sel & ~r_wm_en;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;

  // Last counted ACCESS cycle without ack; an ack on this cycle wins.
  assign w_to = (r_state == S_ACCESS) & ~i_dmem_ack & (r_cnt == CW'(TIMEOUT - 1));

  // Cycle counter: cleared in IDLE so it starts at 0 on ACCESS entry.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)                 r_cnt <= '0;
    else if (r_state == S_IDLE)   r_cnt <= '0;
    else if (!i_dmem_ack && !w_to) r_cnt <= r_cnt + 1'b1;
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_to          = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  // Upstream hold: issuing cycle of a mem op, then every ACCESS cycle that
  // neither completes nor aborts. Forced low while in reset.
  always_comb begin
    w_stall = 1'b0;
    if (i_reset) begin
      case (r_state)
        S_IDLE:   w_stall = w_mem_op;
        S_ACCESS: w_stall = ~i_dmem_ack & ~w_to;
        default:  w_stall = 1'b0;
      endcase
    end
  end

  assign o_stall = w_stall;

  // Access FSM with registered memory-side and MEM/WB outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rw          <= '0;
      r_wr_en       <= 1'b0;
      r_wd_sel      <= 1'b0;
      r_wm_en       <= 1'b0;
      r_valid_wb    <= 1'b0;
      r_wr_en_wb    <= 1'b0;
      r_rw_wb       <= '0;
      r_result_wb   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_valid_wb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_rw       <= i_rw_mem;
            r_wr_en    <= i_wr_en_mem;
            r_wd_sel   <= i_wd_sel_mem;
            r_wm_en    <= i_wm_en_mem;
            r_addr     <= i_alu_result_mem;
            r_wdata    <= i_rdb_mem;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= i_wm_en_mem;
            r_state    <= S_ACCESS;
          end else if (i_valid_mem) begin
            r_valid_wb  <= 1'b1;
            r_wr_en_wb  <= i_wr_en_mem;
            r_rw_wb     <= i_rw_mem;
            r_result_wb <= i_alu_result_mem;
          end
        end
        S_ACCESS: begin
          if (i_dmem_ack) begin
            r_dmem_req  <= 1'b0;
            r_valid_wb  <= 1'b1;
            r_wr_en_wb  <= r_wr_en;
            r_rw_wb     <= r_rw;
            r_result_wb <= w_is_load ? i_dmem_rdata : r_addr;
            r_state     <= S_IDLE;
          end else if (w_to) begin
            // Squashed retire: pipeline resumes, no register write.
            r_dmem_req    <= 1'b0;
            r_valid_wb    <= 1'b1;
            r_wr_en_wb    <= 1'b0;
            r_rw_wb       <= r_rw;
            r_result_wb   <= r_addr;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_wdata = r_wdata;
  assign o_valid_wb   = r_valid_wb;
  assign o_wr_en_wb   = r_wr_en_wb;
  assign o_rw_wb      = r_rw_wb;
  assign o_result_wb  = r_result_wb;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected WB slots,
// a negedge monitor pops and compares on every valid_wb pulse.
module tb_mem_access_stage;

  localparam int N = 32;

  typedef struct packed {
    logic          wr_en;
    logic [4:0]    rw;
    logic [N-1:0]  result;
  } wb_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_mem = 1'b0, wr_en_mem = 1'b0, wd_sel_mem = 1'b0, wm_en_mem = 1'b0;
  logic [4:0]   rw_mem = '0;
  logic [N-1:0] alu_mem = '0, rdb_mem = '0, dmem_rdata = '0;
  logic         dmem_ack = 1'b0;
  logic         stall, dmem_req, dmem_we, valid_wb, wr_en_wb, timeout_err;
  logic [N-1:0] dmem_addr, dmem_wdata, result_wb;
  logic [4:0]   rw_wb;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  wb_t exp_q[$];
  int  wb_hist[$];

  mem_access_stage #(.N(N), .TIMEOUT(16)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_valid_mem(valid_mem), .i_wr_en_mem(wr_en_mem), .i_wd_sel_mem(wd_sel_mem),
    .i_wm_en_mem(wm_en_mem), .i_rw_mem(rw_mem), .i_alu_result_mem(alu_mem),
    .i_rdb_mem(rdb_mem), .o_stall(stall), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata),
    .i_dmem_ack(dmem_ack), .o_valid_wb(valid_wb), .o_wr_en_wb(wr_en_wb),
    .o_rw_wb(rw_wb), .o_result_wb(result_wb), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every WB pulse must match the oldest expected slot.
  always @(negedge clk) begin
    if (rst_n && valid_wb) begin
      wb_t e;
      n_tests++;
      wb_hist.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got wr_en=%0b rw=%0d result=%0h, required no pulse",
                 wr_en_wb, rw_wb, result_wb);
      end else begin
        e = exp_q.pop_front();
        if ({wr_en_wb, rw_wb, result_wb} !== e) begin
          n_fail++;
          $display("FAIL wb_slot: got wr_en=%0b rw=%0d result=%0h, required wr_en=%0b rw=%0d result=%0h",
                   wr_en_wb, rw_wb, result_wb, e.wr_en, e.rw, e.result);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_mem = 1'b0; wr_en_mem = 1'b0; wd_sel_mem = 1'b0; wm_en_mem = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic alu_op(input logic [4:0] rw, input logic wr_en, input logic [N-1:0] res);
    exp_q.push_back('{wr_en: wr_en, rw: rw, result: res});
    valid_mem = 1'b1; wd_sel_mem = 1'b0; wm_en_mem = 1'b0;
    rw_mem = rw; wr_en_mem = wr_en; alu_mem = res;
    @(negedge clk);
    chk("alu_stall", stall, 0);
    step();
    valid_mem = 1'b0;
  endtask

  // Issue a load/store, ack on ACCESS cycle ack_n; check stall/req counts and stability.
  task automatic mem_op(input logic st, input logic both, input logic [4:0] rw, input logic wr_en,
                        input logic [N-1:0] addr, input logic [N-1:0] wdata,
                        input logic [N-1:0] rdata, input int ack_n);
    int   stall_c = 0;
    int   req_c   = 0;
    logic stable  = 1'b1;
    exp_q.push_back('{wr_en: wr_en, rw: rw, result: (st ? addr : rdata)});
    valid_mem = 1'b1; wd_sel_mem = ~st | both; wm_en_mem = st;
    rw_mem = rw; wr_en_mem = wr_en; alu_mem = addr; rdb_mem = wdata;
    @(negedge clk);
    if (stall) stall_c++;
    step();
    for (int k = 1; k <= ack_n; k++) begin
      dmem_ack   = (k == ack_n);
      dmem_rdata = (k == ack_n) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      if (stall)    stall_c++;
      if (dmem_req) req_c++;
      if (dmem_we !== st || dmem_addr !== addr || dmem_wdata !== wdata) stable = 1'b0;
      step();
    end
    idle_inputs();
    chk("mem_stall_cycles", stall_c, ack_n);
    chk("mem_req_cycles", req_c, ack_n);
    chk("mem_bus_stable", stable, 1);
    chk("mem_req_dropped", dmem_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs: every output must be 0.
    for (int i = 0; i < 6; i++) begin
      valid_mem = 1'($urandom); wr_en_mem = 1'($urandom); wd_sel_mem = 1'($urandom);
      wm_en_mem = 1'($urandom); rw_mem = 5'($urandom); alu_mem = $urandom;
      rdb_mem = $urandom; dmem_rdata = $urandom; dmem_ack = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", |{stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, valid_wb,
                             wr_en_wb, rw_wb, result_wb, timeout_err}, 0);
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    step();

    // ALU pass-through.
    alu_op(5'd5, 1'b1, 32'h1234);
    step();

    // Load, ack on third ACCESS cycle.
    mem_op(1'b0, 1'b0, 5'd9, 1'b1, 32'h40, 32'h0, 32'hDEAD_BEEF, 3);
    step();

    // Store, ack after one cycle, then spurious acks in IDLE.
    mem_op(1'b1, 1'b0, 5'd3, 1'b0, 32'h80, 32'hCAFE, 32'h5555_5555, 1);
    for (int i = 0; i < 2; i++) begin
      dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("idle_ack_req", dmem_req, 0);
      chk("idle_ack_stall", stall, 0);
      step();
    end
    idle_inputs();

    // wd_sel and wm_en both set: a store, WB data is the address.
    mem_op(1'b1, 1'b1, 5'd12, 1'b1, 32'h0000_0A5C, 32'h1357_9BDF, 32'hFFFF_0000, 2);
    step();

    // Load immediately followed by an ALU op.
    mem_op(1'b0, 1'b0, 5'd17, 1'b1, 32'h44, 32'h0, 32'h0123_4567, 2);
    alu_op(5'd18, 1'b1, 32'h89AB);
    step();
    chk("b2b_wb_spacing", (wb_hist.size() >= 2) ? wb_hist[wb_hist.size()-1] - wb_hist[wb_hist.size()-2] : -1, 1);

    // Reset mid-ACCESS: dmem_req falls between edges, nothing retires.
    valid_mem = 1'b1; wd_sel_mem = 1'b1; wm_en_mem = 1'b0; rw_mem = 5'd21; alu_mem = 32'h200;
    step();
    @(negedge clk);
    chk("access_req_high", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_req", dmem_req, 0);
    chk("async_reset_stall", stall, 0);
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 16 ACCESS cycles with a squashed retire.
    begin
      int req_c = 0;
      exp_q.push_back('{wr_en: 1'b0, rw: 5'd7, result: 32'h100});
      valid_mem = 1'b1; wd_sel_mem = 1'b1; wm_en_mem = 1'b0; wr_en_mem = 1'b1;
      rw_mem = 5'd7; alu_mem = 32'h100;
      step();
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (dmem_req) req_c++;
        step();
      end
      idle_inputs();
      chk("timeout_req_cycles", req_c, 16);
      chk("timeout_req_dropped", dmem_req, 0);
      chk("timeout_err_set", timeout_err, 1);
      step(); step();
      chk("timeout_err_sticky", timeout_err, 1);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // Ack on the last counted cycle wins over the timeout.
    mem_op(1'b0, 1'b0, 5'd8, 1'b1, 32'h104, 32'h0, 32'hA5A5_5A5A, 16);
    chk("ack16_timeout_err", timeout_err, 0);
`else
    // Without the timeout feature the access waits indefinitely.
    begin
      int req_c = 0;
      valid_mem = 1'b1; wd_sel_mem = 1'b1; wm_en_mem = 1'b0; rw_mem = 5'd7; alu_mem = 32'h100;
      step();
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (dmem_req && stall) req_c++;
        step();
      end
      chk("no_timeout_wait", req_c, 20);
      chk("no_timeout_err", timeout_err, 0);
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
    end
`endif

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
